// File: rtl/srai_accel_axil_pkg.sv
// Shared constants and helpers for the AXI4-Lite register file.
// Response codes and byte-address to word-index conversion.
package srai_accel_axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  function automatic logic [63:0] axil_addr_index(
    input logic [63:0] addr,
    input int unsigned lsb
  );
    return addr >> lsb;
  endfunction

endpackage

// File: rtl/srai_accel_axil_addr_dec.sv
// Address decoder: word index, range check and read-only lookup.
// One instance serves the write path, another the read path.
import srai_accel_axil_pkg::*;

module srai_accel_axil_addr_dec #(
  parameter int AXIL_AW = 12,
  parameter int AXIL_DW = 32,
  parameter int NUM_REGS = 16,
  parameter int IW = 4,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic [AXIL_AW-1:0] addr,
  output logic [IW-1:0]      idx,
  output logic               in_range,
  output logic               ro
);

  localparam int unsigned LSB = $clog2(AXIL_DW / 8);

  logic [63:0] full;

  // Byte offset bits are dropped; any index past the last reg is an error.
  always_comb begin
    full = axil_addr_index(64'(addr), LSB);
    in_range = full < 64'(NUM_REGS);
    idx = full[IW-1:0];
    ro = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (full == 64'(i)) ro = RO_MASK[i];
    end
  end

endmodule

// File: rtl/srai_accel_axil_regfile.sv
// AXI4-Lite slave register file for HLS kernel control/status.
// Independent AW/W holds, 1-cycle read latency, RO and self-clearing bits.
import srai_accel_axil_pkg::*;

module srai_accel_axil_regfile #(
  parameter int AXIL_AW = 12,
  parameter int AXIL_DW = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [NUM_REGS*AXIL_DW-1:0] AUTOCLR_MASK = '0,
  parameter logic [NUM_REGS*AXIL_DW-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIL_AW-1:0]           s_axil_awaddr,
  input  logic [2:0]                   s_axil_awprot,
  input  logic                         s_axil_awvalid,
  output logic                         s_axil_awready,
  input  logic [AXIL_DW-1:0]           s_axil_wdata,
  input  logic [AXIL_DW/8-1:0]         s_axil_wstrb,
  input  logic                         s_axil_wvalid,
  output logic                         s_axil_wready,
  output logic [1:0]                   s_axil_bresp,
  output logic                         s_axil_bvalid,
  input  logic                         s_axil_bready,
  input  logic [AXIL_AW-1:0]           s_axil_araddr,
  input  logic [2:0]                   s_axil_arprot,
  input  logic                         s_axil_arvalid,
  output logic                         s_axil_arready,
  output logic [AXIL_DW-1:0]           s_axil_rdata,
  output logic [1:0]                   s_axil_rresp,
  output logic                         s_axil_rvalid,
  input  logic                         s_axil_rready,
  output logic [NUM_REGS*AXIL_DW-1:0]  reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse,
  input  logic [NUM_REGS*AXIL_DW-1:0]  ro_d
);

  localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int SW = AXIL_DW / 8;

  logic                        rdy_en;
  logic                        aw_held;
  logic [AXIL_AW-1:0]          aw_addr_q;
  logic                        w_held;
  logic [AXIL_DW-1:0]          w_data_q;
  logic [SW-1:0]               w_strb_q;
  logic                        bvalid_q;
  logic [1:0]                  bresp_q;
  logic                        rvalid_q;
  logic [AXIL_DW-1:0]          rdata_q;
  logic [1:0]                  rresp_q;
  logic [NUM_REGS*AXIL_DW-1:0] regs;
  logic [NUM_REGS*AXIL_DW-1:0] regs_nxt;
  logic [NUM_REGS-1:0]         pulse_nxt;

  logic                        aw_hs;
  logic                        w_hs;
  logic                        ar_hs;
  logic                        commit;
  logic [AXIL_AW-1:0]          aw_addr_eff;
  logic [AXIL_DW-1:0]          w_data_eff;
  logic [SW-1:0]               w_strb_eff;

  logic [IW-1:0]               wr_idx;
  logic                        wr_in_range;
  logic                        wr_ro;
  logic [IW-1:0]               rd_idx;
  logic                        rd_in_range;
  logic                        rd_ro;
  logic [AXIL_DW-1:0]          rd_rw;
  logic [AXIL_DW-1:0]          rd_st;
  logic [AXIL_DW-1:0]          rd_val;

  logic                        unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  assign s_axil_awready = rdy_en & ~aw_held & ~bvalid_q;
  assign s_axil_wready  = rdy_en & ~w_held & ~bvalid_q;
  assign s_axil_arready = rdy_en & ~rvalid_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = bresp_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign reg_q          = regs;

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid & s_axil_wready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;

  assign aw_addr_eff = aw_held ? aw_addr_q : s_axil_awaddr;
  assign w_data_eff  = w_held ? w_data_q : s_axil_wdata;
  assign w_strb_eff  = w_held ? w_strb_q : s_axil_wstrb;
  assign commit = (aw_held | aw_hs) & (w_held | w_hs);

  srai_accel_axil_addr_dec #(
    .AXIL_AW (AXIL_AW),
    .AXIL_DW (AXIL_DW),
    .NUM_REGS(NUM_REGS),
    .IW      (IW),
    .RO_MASK (RO_MASK)
  ) u_wr_dec (
    .addr    (aw_addr_eff),
    .idx     (wr_idx),
    .in_range(wr_in_range),
    .ro      (wr_ro)
  );

  srai_accel_axil_addr_dec #(
    .AXIL_AW (AXIL_AW),
    .AXIL_DW (AXIL_DW),
    .NUM_REGS(NUM_REGS),
    .IW      (IW),
    .RO_MASK (RO_MASK)
  ) u_rd_dec (
    .addr    (s_axil_araddr),
    .idx     (rd_idx),
    .in_range(rd_in_range),
    .ro      (rd_ro)
  );

  // Readys stay low while in reset and for the first cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  // Next register image: self-clearing bits drop, then strobed bytes land.
  always_comb begin
    regs_nxt = regs & ~AUTOCLR_MASK;
    pulse_nxt = '0;
    if (commit && wr_in_range && !wr_ro) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IW'(i)) begin
          pulse_nxt[i] = 1'b1;
          for (int b = 0; b < SW; b++) begin
            if (w_strb_eff[b]) begin
              regs_nxt[i*AXIL_DW + b*8 +: 8] = w_data_eff[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  // Read mux: RO regs return the status input, out-of-range returns 0.
  always_comb begin
    rd_rw = '0;
    rd_st = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IW'(i)) begin
        rd_rw = regs[i*AXIL_DW +: AXIL_DW];
        rd_st = ro_d[i*AXIL_DW +: AXIL_DW];
      end
    end
    rd_val = !rd_in_range ? '0 : (rd_ro ? rd_st : rd_rw);
  end

  // Register storage and one-cycle write pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs     <= RST_VAL;
      wr_pulse <= '0;
    end else begin
      regs     <= regs_nxt;
      wr_pulse <= pulse_nxt;
    end
  end

  // Write channel: AW/W holds, commit, then B until bready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      aw_addr_q <= '0;
      w_held    <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= AXIL_RESP_OKAY;
    end else begin
      if (commit) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= s_axil_awaddr;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil_wdata;
          w_strb_q <= s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
      end
    end
  end

  // Read channel: capture on AR handshake, hold until rready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= AXIL_RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
      rresp_q  <= rd_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

endmodule
